// File: rtl/muldiv_seq_16.sv
// Iterative 16x16 unsigned multiplier / 16/16 unsigned divider that borrows an
// external combinational alu_16 for one add or subtract per clock.
module muldiv_seq_16 #(
  parameter logic [3:0] OP_ADD = 4'b1001,
  parameter logic [3:0] OP_SUB = 4'b0110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [15:0] res_hi,
  output logic [15:0] res_lo,
  output logic [3:0]  alu_op,
  output logic        alu_mode,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_cin,
  input  logic [15:0] alu_z,
  input  logic        alu_cout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic        is_div;
  logic [15:0] acc;     // hi (MUL) / partial remainder r (DIV)
  logic [15:0] lo;      // multiplier bits lo (MUL) / quotient q (DIV)
  logic [15:0] opnd;    // multiplicand mc (MUL) / divisor d (DIV)
  logic [15:0] acc_nxt, lo_nxt, shift_r, sum_s;
  logic        sum_c, take;
  logic        accept, div_by_zero, running, last_iter;

  assign accept      = start && (state != RUN);
  assign div_by_zero = accept && op_div && (b == 16'd0);
  assign running     = (state == RUN);
  assign last_iter   = running && (count == 4'd15);

  assign busy      = running;
  assign done      = (state == DONE);
  assign dbg_state = state;

  // Idle drive is a harmless 0+0 add with no carry in.
  assign shift_r  = {acc[14:0], lo[15]};
  assign alu_mode = 1'b0;
  assign alu_op   = (running && is_div) ? OP_SUB : OP_ADD;
  assign alu_cin  = !(running && is_div);
  assign alu_x    = running ? (is_div ? shift_r : acc) : 16'd0;
  assign alu_y    = running ? opnd : 16'd0;

  always_comb begin
    sum_c   = 1'b0;
    sum_s   = acc;
    take    = 1'b0;
    acc_nxt = acc;
    lo_nxt  = lo;
    if (is_div) begin
      // r[15] set means the shifted remainder is 17 bits wide, so it always covers d.
      take    = acc[15] || !alu_cout;
      acc_nxt = take ? alu_z : shift_r;
      lo_nxt  = {lo[14:0], take};
    end else begin
      if (lo[0]) begin
        sum_c = !alu_cout;
        sum_s = alu_z;
      end
      acc_nxt = {sum_c, sum_s[15:1]};
      lo_nxt  = {sum_s[0], lo[15:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = div_by_zero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (count == 4'd15) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      is_div <= 1'b0;
      acc    <= 16'd0;
      lo     <= 16'd0;
      opnd   <= 16'd0;
      div0   <= 1'b0;
      res_hi <= 16'd0;
      res_lo <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count  <= 4'd0;
        is_div <= op_div;
        acc    <= 16'd0;
        lo     <= op_div ? a : b;
        opnd   <= op_div ? b : a;
        div0   <= div_by_zero;
        if (div_by_zero) begin
          res_hi <= a;
          res_lo <= 16'hFFFF;
        end
      end else if (running) begin
        count <= count + 4'd1;
        acc   <= acc_nxt;
        lo    <= lo_nxt;
        if (last_iter) begin
          res_hi <= acc_nxt;
          res_lo <= lo_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_16.sv
// Directed bench for muldiv_seq_16 with a behavioural alu_16 attached to the
// initiator port.
module tb_muldiv_seq_16;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        reset, start, op_div;
  logic [15:0] a, b;
  logic        busy, done, div0;
  logic [15:0] res_hi, res_lo;
  logic [3:0]  alu_op;
  logic        alu_mode, alu_cin, alu_cout;
  logic [15:0] alu_x, alu_y, alu_z;
  logic [1:0]  dbg_state;
  logic [16:0] alu_sum;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_seq_16 dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .res_hi(res_hi), .res_lo(res_lo),
    .alu_op(alu_op), .alu_mode(alu_mode), .alu_x(alu_x), .alu_y(alu_y),
    .alu_cin(alu_cin), .alu_z(alu_z), .alu_cout(alu_cout), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // alu_16 model: active-low carry in and out; SUB is x + ~y + carry.
  always_comb begin
    alu_sum = {1'b0, alu_x} + {1'b0, (alu_op == OP_SUB) ? ~alu_y : alu_y}
            + {16'd0, ~alu_cin};
  end
  assign alu_z    = alu_sum[15:0];
  assign alu_cout = ~alu_sum[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Driver tasks: inputs change #1 after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic div, input logic [15:0] av, input logic [15:0] bv);
    start  = 1'b1;
    op_div = div;
    a      = av;
    b      = bv;
    tick();
    start  = 1'b0;
    a      = 16'h0;
    b      = 16'h0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic div, input logic [15:0] av,
                        input logic [15:0] bv, input logic [31:0] exp_res,
                        input logic exp_div0, input int exp_lat);
    int lat;
    start_op(div, av, bv);
    if (exp_lat > 0) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_aluop"}, {28'd0, alu_op}, {28'd0, div ? OP_SUB : OP_ADD});
      check({tag, "_alucin"}, {31'd0, alu_cin}, {31'd0, ~div});
      check({tag, "_div0_clr"}, {31'd0, div0}, 32'd0);
    end
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, {res_hi, res_lo}, exp_res);
    check({tag, "_div0"}, {31'd0, div0}, {31'd0, exp_div0});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, nd;
    reset  = 1'b1;
    start  = 1'b0;
    op_div = 1'b0;
    a      = 16'h0;
    b      = 16'h0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div0", {31'd0, div0}, 32'd0);
    check("rst_res", {res_hi, res_lo}, 32'h0);
    check("rst_aluop", {28'd0, alu_op}, {28'd0, OP_ADD});
    check("rst_alu_xy", {alu_x, alu_y}, 32'h0);
    check("rst_alucin", {30'd0, alu_cin, alu_mode}, 32'd2);
    // Reset wins over start.
    start_op(1'b0, 16'd3, 16'd5);
    check("rst_over_start", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mul_3x5", 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0, 16);
    run_op("mul_max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 16);
    run_op("mul_0", 1'b0, 16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 16);
    run_op("div_100_7", 1'b1, 16'h0064, 16'h0007, 32'h0002_000E, 1'b0, 16);
    run_op("div_ffff_1", 1'b1, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 16);
    run_op("div_big", 1'b1, 16'hFFFF, 16'h8001, 32'h7FFE_0001, 1'b0, 16);
    run_op("div_by0", 1'b1, 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b1, 0);
    run_op("mul_after0", 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0, 16);

    // Start while busy is ignored.
    start_op(1'b0, 16'h0007, 16'h0009);
    repeat (4) tick();
    start_op(1'b1, 16'hFFFF, 16'h0002);
    wait_done(lat);
    check("ign_lat", lat + 5, 32'd16);
    check("ign_res", {res_hi, res_lo}, 32'h0000_003F);
    tick();

    // Back-to-back: second start lands in the DONE cycle.
    start_op(1'b0, 16'h1234, 16'h0010);
    wait_done(lat);
    check("b2b_first", {res_hi, res_lo}, 32'h0001_2340);
    start_op(1'b1, 16'h03E8, 16'h000A);
    check("b2b_accept", {31'd0, busy}, 32'd1);
    repeat (8) tick();
    check("b2b_hold", {res_hi, res_lo}, 32'h0001_2340);
    wait_done(lat);
    check("b2b_lat", lat + 8, 32'd16);
    check("b2b_second", {res_hi, res_lo}, 32'h0000_0064);
    tick();

    // Reset during RUN abandons the operation.
    start_op(1'b0, 16'h00FF, 16'h00FF);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_res", {res_hi, res_lo}, 32'h0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    nd = 0;
    repeat (20) begin
      tick();
      if (done) nd++;
    end
    check("mid_rst_nodone", nd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
